piece_controller: RTL and testbench

- Sequences the active tetromino for the game core.
- Latches player commands (left, right, rotate, hard drop) and gravity ticks, and runs the board collision checker via an enable/complete handshake.
- Applies at most one move per check and updates the anchor/rotation registers that feed the collision checker, renderer and board writer.
- Requests a lock when the piece cannot fall, spawns the next piece from the random generator, and flags game over.

---
 rtl/piece_controller.sv | 182 ++++++++++++++++++
 tb/tb_piece_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_controller.sv
`default_nettype none
//==============================================================================
// Module  : piece_controller
// Purpose : Active-tetromino sequencer. Latches moves, runs the collision
//           checker handshake, applies one move per check, locks and spawns.
// Rev     : 1.0  initial release
//==============================================================================
module piece_controller #(
    parameter logic [4:0] SPAWN_X = 5'd4,
    parameter logic [5:0] SPAWN_Y = 6'd0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_rotate,
    input  logic       key_drop,
    input  logic       tick,
    input  logic [2:0] new_block,
    input  logic       col_left,
    input  logic       col_right,
    input  logic       col_down,
    input  logic       col_rotate,
    input  logic       col_complete,
    input  logic       lock_ack,
    output logic       col_enable,
    output logic [4:0] X_anchor,
    output logic [5:0] Y_anchor,
    output logic [2:0] block,
    output logic [1:0] curr_rotation,
    output logic       lock_req,
    output logic       block_take,
    output logic       game_over
);

    localparam logic [2:0] c_st_spawn    = 3'd0;
    localparam logic [2:0] c_st_idle     = 3'd1;
    localparam logic [2:0] c_st_check    = 3'd2;
    localparam logic [2:0] c_st_apply    = 3'd3;
    localparam logic [2:0] c_st_lock     = 3'd4;
    localparam logic [2:0] c_st_gameover = 3'd5;

    // Pending bit order doubles as service priority: rot > left > right > down
    localparam int c_p_rot   = 3;
    localparam int c_p_left  = 2;
    localparam int c_p_right = 1;
    localparam int c_p_down  = 0;

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [3:0] r_pend;
    logic [3:0] w_pend_set;
    logic [3:0] w_pend_clr;
    logic       r_drop;
    logic       r_col_left;
    logic       r_col_right;
    logic       r_col_down;
    logic       r_col_rotate;
    logic [4:0] r_x;
    logic [5:0] r_y;
    logic [2:0] r_block;
    logic [1:0] r_rot;
    logic       r_block_take;
    logic       w_serve_down;

    assign w_pend_set   = {key_rotate, key_left, key_right, key_drop | tick};
    assign w_serve_down = (r_pend[3:1] == 3'b000) && (r_pend[c_p_down] || r_drop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_st_spawn;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_spawn:    w_state_next = c_st_idle;
            c_st_idle:     if ((|r_pend) || r_drop) w_state_next = c_st_check;
            c_st_check:    if (col_complete) w_state_next = c_st_apply;
            c_st_apply:    w_state_next = (w_serve_down && r_col_down) ? c_st_lock : c_st_idle;
            c_st_lock: begin
                if (lock_ack) begin
                    w_state_next = (r_y == SPAWN_Y) ? c_st_gameover : c_st_spawn;
                end
            end
            c_st_gameover: w_state_next = c_st_gameover;
            default:       w_state_next = c_st_spawn;
        endcase
    end

    always_comb begin
        col_enable = 1'b0;
        lock_req   = 1'b0;
        game_over  = 1'b0;
        case (r_state)
            c_st_check:    col_enable = 1'b1;
            c_st_lock:     lock_req   = 1'b1;
            c_st_gameover: game_over  = 1'b1;
            default:       ;
        endcase
    end

    always_comb begin
        w_pend_clr = 4'b0000;
        if (r_state == c_st_apply) begin
            if (r_pend[c_p_rot])        w_pend_clr = 4'b1000;
            else if (r_pend[c_p_left])  w_pend_clr = 4'b0100;
            else if (r_pend[c_p_right]) w_pend_clr = 4'b0010;
            else                        w_pend_clr = 4'b0001;
        end
    end

    // A new pulse in the APPLY cycle survives the clear of the same bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend <= 4'b0000;
            r_drop <= 1'b0;
        end else if (r_state == c_st_spawn) begin
            r_pend <= 4'b0000;
            r_drop <= 1'b0;
        end else if (r_state != c_st_gameover) begin
            r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
            r_drop <= r_drop | key_drop;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_block      <= 3'd0;
            r_x          <= SPAWN_X;
            r_y          <= SPAWN_Y;
            r_rot        <= 2'd0;
            r_block_take <= 1'b0;
            r_col_left   <= 1'b0;
            r_col_right  <= 1'b0;
            r_col_down   <= 1'b0;
            r_col_rotate <= 1'b0;
        end else begin
            r_block_take <= 1'b0;
            case (r_state)
                c_st_spawn: begin
                    r_block      <= new_block;
                    r_x          <= SPAWN_X;
                    r_y          <= SPAWN_Y;
                    r_rot        <= 2'd0;
                    r_block_take <= 1'b1;
                end
                c_st_check: begin
                    if (col_complete) begin
                        r_col_left   <= col_left;
                        r_col_right  <= col_right;
                        r_col_down   <= col_down;
                        r_col_rotate <= col_rotate;
                    end
                end
                c_st_apply: begin
                    if (r_pend[c_p_rot]) begin
                        if (!r_col_rotate) r_rot <= r_rot + 2'd1;
                    end else if (r_pend[c_p_left]) begin
                        if (!r_col_left) r_x <= r_x - 5'd1;
                    end else if (r_pend[c_p_right]) begin
                        if (!r_col_right) r_x <= r_x + 5'd1;
                    end else if (w_serve_down && !r_col_down) begin
                        r_y <= r_y + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign X_anchor      = r_x;
    assign Y_anchor      = r_y;
    assign block         = r_block;
    assign curr_rotation = r_rot;
    assign block_take    = r_block_take;

endmodule
`default_nettype wire

// File: tb/tb_piece_controller.sv
`default_nettype none
//==============================================================================
// Module  : tb_piece_controller
// Purpose : Self-checking bench for piece_controller with a move-level model.
// Rev     : 1.0  initial release
//==============================================================================
module tb_piece_controller;

    localparam logic [4:0] SPAWN_X = 5'd4;
    localparam logic [5:0] SPAWN_Y = 6'd0;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       key_left = 1'b0, key_right = 1'b0, key_rotate = 1'b0, key_drop = 1'b0, tick = 1'b0;
    logic [2:0] new_block = 3'd3;
    logic       col_left = 1'b0, col_right = 1'b0, col_down = 1'b0, col_rotate = 1'b0;
    logic       col_complete = 1'b0, lock_ack = 1'b0;
    logic       col_enable, lock_req, block_take, game_over;
    logic [4:0] X_anchor;
    logic [5:0] Y_anchor;
    logic [2:0] block;
    logic [1:0] curr_rotation;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: piece position and the set of outstanding commands
    int m_x, m_y, m_rot, m_block;
    bit m_p_rot, m_p_left, m_p_right, m_p_down, m_drop, m_over;

    always #5 clk = ~clk;

    piece_controller #(.SPAWN_X(SPAWN_X), .SPAWN_Y(SPAWN_Y)) dut (
        .clk(clk), .resetn(resetn),
        .key_left(key_left), .key_right(key_right), .key_rotate(key_rotate),
        .key_drop(key_drop), .tick(tick), .new_block(new_block),
        .col_left(col_left), .col_right(col_right), .col_down(col_down),
        .col_rotate(col_rotate), .col_complete(col_complete), .lock_ack(lock_ack),
        .col_enable(col_enable), .X_anchor(X_anchor), .Y_anchor(Y_anchor),
        .block(block), .curr_rotation(curr_rotation), .lock_req(lock_req),
        .block_take(block_take), .game_over(game_over)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_spawn();
        m_x = SPAWN_X; m_y = SPAWN_Y; m_rot = 0; m_block = new_block;
        m_p_rot = 0; m_p_left = 0; m_p_right = 0; m_p_down = 0; m_drop = 0;
    endtask

    task automatic reset_check();
        check_val("rst_x", X_anchor, SPAWN_X);
        check_val("rst_y", Y_anchor, SPAWN_Y);
        check_val("rst_block", block, 0);
        check_val("rst_rot", curr_rotation, 0);
        check_val("rst_col_en", col_enable, 0);
        check_val("rst_lock_req", lock_req, 0);
        check_val("rst_block_take", block_take, 0);
        check_val("rst_game_over", game_over, 0);
    endtask

    task automatic spawn_check();
        check_val("spawn_block", block, m_block);
        check_val("spawn_x", X_anchor, m_x);
        check_val("spawn_y", Y_anchor, m_y);
        check_val("spawn_rot", curr_rotation, 0);
        check_val("spawn_take", block_take, 1);
        step();
        check_val("take_pulse_end", block_take, 0);
        check_val("idle_col_en", col_enable, 0);
    endtask

    task automatic release_reset(input logic [2:0] nb);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        new_block = nb;
        m_over = 0;
        step();
        model_spawn();
        spawn_check();
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        #2;
        reset_check();
        release_reset(3'($urandom_range(0, 7)));
    endtask

    task automatic pulse(input bit kl, input bit kr, input bit krot, input bit kd, input bit kt);
        key_left = kl; key_right = kr; key_rotate = krot; key_drop = kd; tick = kt;
        step();
        key_left = 0; key_right = 0; key_rotate = 0; key_drop = 0; tick = 0;
        if (!m_over) begin
            m_p_left  |= kl;
            m_p_right |= kr;
            m_p_rot   |= krot;
            m_p_down  |= kd | kt;
            m_drop    |= kd;
        end
    endtask

    task automatic model_apply(input bit fl, input bit fr, input bit fd, input bit frot, output bit lk);
        lk = 0;
        if (m_p_rot) begin
            if (!frot) m_rot = (m_rot + 1) % 4;
            m_p_rot = 0;
        end else if (m_p_left) begin
            if (!fl) m_x = m_x - 1;
            m_p_left = 0;
        end else if (m_p_right) begin
            if (!fr) m_x = m_x + 1;
            m_p_right = 0;
        end else begin
            if (!fd) m_y = m_y + 1;
            else     lk = 1;
            m_p_down = 0;
        end
    endtask

    task automatic serve(input int dly, input bit fl, input bit fr, input bit fd, input bit frot, output bit lk);
        int guard;
        guard = 0;
        lk = 0;
        while (col_enable !== 1'b1 && guard < 10) begin
            step();
            guard++;
        end
        check_val("check_entered", col_enable, 1);
        if (col_enable !== 1'b1) return;
        repeat (dly) step();
        col_complete = 1; col_left = fl; col_right = fr; col_down = fd; col_rotate = frot;
        step();
        col_complete = 0; col_left = 0; col_right = 0; col_down = 0; col_rotate = 0;
        check_val("col_en_apply", col_enable, 0);
        model_apply(fl, fr, fd, frot, lk);
        step();
        check_val("x_anchor", X_anchor, m_x);
        check_val("y_anchor", Y_anchor, m_y);
        check_val("rotation", curr_rotation, m_rot);
        check_val("lock_req_state", lock_req, lk);
    endtask

    task automatic do_lock(input int dly);
        int guard;
        guard = 0;
        while (lock_req !== 1'b1 && guard < 10) begin
            step();
            guard++;
        end
        check_val("lock_req_up", lock_req, 1);
        repeat (dly) step();
        check_val("lock_req_hold", lock_req, 1);
        lock_ack = 1;
        step();
        lock_ack = 0;
        check_val("lock_req_drop", lock_req, 0);
        if (m_y == SPAWN_Y) begin
            m_over = 1;
            check_val("game_over_set", game_over, 1);
        end else begin
            new_block = 3'($urandom_range(0, 7));
            step();
            model_spawn();
            spawn_check();
        end
    endtask

    task automatic quiet(input int n);
        bit seen;
        seen = 0;
        repeat (n) begin
            step();
            if (col_enable !== 1'b0) seen = 1;
        end
        check_val("no_extra_check", seen, 0);
    endtask

    initial begin
        bit lk;
        m_over = 0;
        #12;
        reset_check();
        release_reset(3'd3);

        // Single left move with a slow checker
        pulse(1, 0, 0, 0, 0);
        serve(20, 0, 0, 0, 0, lk);

        // Rotate and right together: two separate checks, rotate first
        pulse(0, 1, 1, 0, 0);
        serve(3, 0, 0, 0, 0, lk);
        serve(2, 0, 0, 0, 0, lk);
        quiet(5);

        // Walk to the left wall, then a blocked left is discarded
        while (m_x > 0) begin
            pulse(1, 0, 0, 0, 0);
            serve($urandom_range(0, 2), 0, 0, 0, 0, lk);
        end
        pulse(1, 0, 0, 0, 0);
        serve(1, 1, 0, 0, 0, lk);
        quiet(4);

        // Rotation wraps 3 -> 0
        while (m_rot != 3) begin
            pulse(0, 0, 1, 0, 0);
            serve(0, 0, 0, 0, 0, lk);
        end
        pulse(0, 0, 1, 0, 0);
        serve(1, 0, 0, 0, 0, lk);
        check_val("rot_wrap", curr_rotation, 0);

        // Randomized play against the model
        for (int it = 0; it < 40; it++) begin
            bit kl, kr, krot, kd, kt, fl, fr, fd, frot;
            int guard;
            kl = 1'($urandom_range(0, 1));
            kr = 1'($urandom_range(0, 1));
            krot = 1'($urandom_range(0, 1));
            kd = ($urandom_range(0, 9) == 0);
            kt = ($urandom_range(0, 3) == 0);
            if (!(kl | kr | krot | kd | kt)) kl = 1;
            pulse(kl, kr, krot, kd, kt);
            guard = 0;
            while ((m_p_rot || m_p_left || m_p_right || m_p_down || m_drop) && !m_over && guard < 64) begin
                fl   = (m_x == 0) || ($urandom_range(0, 3) == 0);
                fr   = (m_x == 9) || ($urandom_range(0, 3) == 0);
                fd   = (m_y == 23) || (m_y != 0 && $urandom_range(0, 2) == 0);
                frot = ($urandom_range(0, 3) == 0);
                serve($urandom_range(0, 4), fl, fr, fd, frot, lk);
                if (lk) do_lock($urandom_range(0, 3));
                guard++;
            end
        end

        // Hard drop: five free falls without tick, then lock and respawn
        apply_reset();
        pulse(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) serve($urandom_range(0, 3), 0, 0, 0, 0, lk);
        serve(1, 0, 0, 1, 0, lk);
        check_val("drop_lock", lk, 1);
        check_val("drop_y", Y_anchor, 5);
        do_lock(3);

        // Lock at spawn row ends the game; keys are then ignored
        pulse(0, 0, 0, 0, 1);
        serve(0, 0, 0, 1, 0, lk);
        do_lock(2);
        pulse(1, 1, 1, 1, 1);
        quiet(6);
        check_val("game_over_sticky", game_over, 1);
        check_val("gameover_x_hold", X_anchor, m_x);

        // Asynchronous reset in the middle of a check
        apply_reset();
        pulse(1, 0, 0, 0, 0);
        begin
            int guard;
            guard = 0;
            while (col_enable !== 1'b1 && guard < 10) begin
                step();
                guard++;
            end
        end
        check_val("midcheck_col_en", col_enable, 1);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        reset_check();
        release_reset(3'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
